// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32I decode definitions for the decode stage.
// Contents: opcodes, ALU op codes (including the Jal/Jalr link ops), the
// op1 source select, the decoded-instruction struct and the decode function.
package id_stage_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0f;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;
  localparam logic [5:0] ALU_LUI  = 6'd10; // pass op2
  localparam logic [5:0] ALU_BR   = 6'd11; // branch: no EX result
  localparam logic [5:0] ALU_LB   = 6'd16; // loads: ALU_LB + funct3
  localparam logic [5:0] ALU_SB   = 6'd24; // stores: ALU_SB + funct3
  localparam logic [5:0] ALU_JAL  = 6'd32; // op1 carries the link value
  localparam logic [5:0] ALU_JALR = 6'd33;

  typedef enum logic [1:0] {OP1_RS, OP1_ZERO, OP1_PC, OP1_PC4} op1_sel_e;

  typedef struct packed {
    logic [5:0]  aluop;
    logic [31:0] imm;
    op1_sel_e    op1_sel;
    logic        op2_imm;
    logic        use1;
    logic        use2;
    logic        wreg;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i;
    f3 = inst[14:12];
    f7 = inst[31:25];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    d = '0;
    d.aluop   = ALU_ADD;
    d.op1_sel = OP1_RS;
    d.op2_imm = 1'b1;
    case (inst[6:0])
      OPC_LUI: begin
        d.imm = {inst[31:12], 12'b0}; d.aluop = ALU_LUI; d.wreg = 1'b1; d.op1_sel = OP1_ZERO;
      end
      OPC_AUIPC: begin
        d.imm = {inst[31:12], 12'b0}; d.wreg = 1'b1; d.op1_sel = OP1_PC;
      end
      OPC_JAL: begin
        d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        d.aluop = ALU_JAL; d.wreg = 1'b1; d.op1_sel = OP1_PC4; d.is_jal = 1'b1;
      end
      OPC_JALR: begin
        d.imm = imm_i; d.use1 = 1'b1; d.aluop = ALU_JALR; d.wreg = 1'b1;
        d.op1_sel = OP1_PC4; d.is_jalr = 1'b1; d.illegal = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        d.use1 = 1'b1; d.use2 = 1'b1; d.op2_imm = 1'b0; d.aluop = ALU_BR; d.is_br = 1'b1;
        d.illegal = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LOAD: begin
        d.imm = imm_i; d.use1 = 1'b1; d.wreg = 1'b1; d.aluop = ALU_LB + {3'b0, f3};
        d.illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        d.use1 = 1'b1; d.use2 = 1'b1; d.op2_imm = 1'b0; d.aluop = ALU_SB + {3'b0, f3};
        d.illegal = (f3 > 3'd2);
      end
      OPC_OPIMM: begin
        d.imm = imm_i; d.use1 = 1'b1; d.wreg = 1'b1;
        case (f3)
          3'd0: d.aluop = ALU_ADD;
          3'd2: d.aluop = ALU_SLT;
          3'd3: d.aluop = ALU_SLTU;   // immediate still sign-extended
          3'd4: d.aluop = ALU_XOR;
          3'd6: d.aluop = ALU_OR;
          3'd7: d.aluop = ALU_AND;
          3'd1: begin
            d.imm = {27'b0, inst[24:20]}; d.aluop = ALU_SLL; d.illegal = (f7 != F7_BASE);
          end
          default: begin
            d.imm = {27'b0, inst[24:20]};
            d.aluop = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            d.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        d.use1 = 1'b1; d.use2 = 1'b1; d.op2_imm = 1'b0; d.wreg = 1'b1;
        case ({f7, f3})
          {F7_BASE, 3'd0}: d.aluop = ALU_ADD;
          {F7_ALT,  3'd0}: d.aluop = ALU_SUB;
          {F7_BASE, 3'd1}: d.aluop = ALU_SLL;
          {F7_BASE, 3'd2}: d.aluop = ALU_SLT;
          {F7_BASE, 3'd3}: d.aluop = ALU_SLTU;
          {F7_BASE, 3'd4}: d.aluop = ALU_XOR;
          {F7_BASE, 3'd5}: d.aluop = ALU_SRL;
          {F7_ALT,  3'd5}: d.aluop = ALU_SRA;
          {F7_BASE, 3'd6}: d.aluop = ALU_OR;
          {F7_BASE, 3'd7}: d.aluop = ALU_AND;
          default:         d.illegal = 1'b1;
        endcase
      end
      OPC_FENCE: d.op1_sel = OP1_ZERO;  // single-issue in-order: FENCE is a NOP
      default:   d.illegal = 1'b1;
    endcase
    // Undecodable words travel down the pipe as an all-zero NOP.
    if (d.illegal) begin
      d = '0;
      d.illegal = 1'b1;
      d.op1_sel = OP1_ZERO;
      d.op2_imm = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/id_stage_pipe_operand_fwd.sv
// id_operand_fwd: selects the value of one source register.
// Ports: rs_i (register index), rf_data_i (regfile value), fwd_valid_i /
// fwd_pend_i / fwd_rd_i / fwd_data_i (bypass sources, index 0 youngest),
// data_o (selected value), hazard_o (selected source is still pending).
module id_operand_fwd #(
  parameter int XLEN      = 32,
  parameter int FWD_PORTS = 2,
  parameter int REG_AW    = 5
) (
  input  logic [REG_AW-1:0]           rs_i,
  input  logic [XLEN-1:0]             rf_data_i,
  input  logic [FWD_PORTS-1:0]        fwd_valid_i,
  input  logic [FWD_PORTS-1:0]        fwd_pend_i,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_rd_i,
  input  logic [FWD_PORTS*XLEN-1:0]   fwd_data_i,
  output logic [XLEN-1:0]             data_o,
  output logic                        hazard_o
);

  logic [FWD_PORTS-1:0] hit;
  logic [XLEN-1:0]      src_data [FWD_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < FWD_PORTS; gi++) begin : g_src
      assign hit[gi]      = fwd_valid_i[gi] && (fwd_rd_i[gi*REG_AW +: REG_AW] == rs_i);
      assign src_data[gi] = fwd_data_i[gi*XLEN +: XLEN];
    end
  endgenerate

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    for (int n = FWD_PORTS - 1; n >= 0; n--) begin
      if (hit[n]) begin
        data_o   = src_data[n];
        hazard_o = fwd_pend_i[n];
      end
    end
    if (rs_i == '0) begin
      data_o   = '0;
      hazard_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I decode stage between IF and EX.
// Ports: clk/rst (async high), flush_i; IF handshake (if_valid_i, if_ready_o,
// if_pc_i, if_inst_i); regfile read (rf_raddr*_o, rf_rdata*_i); bypass
// sources (fwd_*_i); EX payload with valid/ready (ex_*); redirect_o /
// redirect_pc_o and illegal_o one-cycle pulses.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FWD_PORTS = 2,
  parameter int REG_AW    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        if_valid_i,
  output logic                        if_ready_o,
  input  logic [XLEN-1:0]             if_pc_i,
  input  logic [31:0]                 if_inst_i,
  output logic [REG_AW-1:0]           rf_raddr1_o,
  output logic [REG_AW-1:0]           rf_raddr2_o,
  input  logic [XLEN-1:0]             rf_rdata1_i,
  input  logic [XLEN-1:0]             rf_rdata2_i,
  input  logic [FWD_PORTS-1:0]        fwd_valid_i,
  input  logic [FWD_PORTS-1:0]        fwd_pend_i,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_rd_i,
  input  logic [FWD_PORTS*XLEN-1:0]   fwd_data_i,
  output logic                        ex_valid_o,
  input  logic                        ex_ready_i,
  output logic [5:0]                  ex_aluop_o,
  output logic [XLEN-1:0]             ex_op1_o,
  output logic [XLEN-1:0]             ex_op2_o,
  output logic [XLEN-1:0]             ex_imm_o,
  output logic [XLEN-1:0]             ex_pc_o,
  output logic [REG_AW-1:0]           ex_rd_o,
  output logic                        ex_wreg_o,
  output logic                        redirect_o,
  output logic [XLEN-1:0]             redirect_pc_o,
  output logic                        illegal_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_SQUASH = 1'b1} state_e;
  state_e state_q, state_d;

  dec_t              dec;
  logic [XLEN-1:0]   imm, rs1_data, rs2_data, op1, op2, target;
  logic              hz1, hz2, hazard, br_cond, taken, discard, issue;

  logic              ex_valid_q, ex_wreg_q, redirect_q, illegal_q;
  logic [5:0]        ex_aluop_q;
  logic [XLEN-1:0]   ex_op1_q, ex_op2_q, ex_imm_q, ex_pc_q, redirect_pc_q, target_q;
  logic [REG_AW-1:0] ex_rd_q;

  assign dec         = decode(if_inst_i);
  assign imm         = XLEN'($signed(dec.imm));
  assign rf_raddr1_o = REG_AW'(if_inst_i[19:15]);
  assign rf_raddr2_o = REG_AW'(if_inst_i[24:20]);

  id_operand_fwd #(.XLEN(XLEN), .FWD_PORTS(FWD_PORTS), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_i(rf_raddr1_o), .rf_data_i(rf_rdata1_i), .fwd_valid_i(fwd_valid_i),
    .fwd_pend_i(fwd_pend_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .data_o(rs1_data), .hazard_o(hz1)
  );

  id_operand_fwd #(.XLEN(XLEN), .FWD_PORTS(FWD_PORTS), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_i(rf_raddr2_o), .rf_data_i(rf_rdata2_i), .fwd_valid_i(fwd_valid_i),
    .fwd_pend_i(fwd_pend_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .data_o(rs2_data), .hazard_o(hz2)
  );

  assign hazard = (dec.use1 && hz1) || (dec.use2 && hz2);

  always_comb begin
    case (if_inst_i[14:12])
      3'd0:    br_cond = (rs1_data == rs2_data);
      3'd1:    br_cond = (rs1_data != rs2_data);
      3'd4:    br_cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'd5:    br_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'd6:    br_cond = (rs1_data <  rs2_data);
      3'd7:    br_cond = (rs1_data >= rs2_data);
      default: br_cond = 1'b0;
    endcase
  end

  assign taken  = dec.is_jal || dec.is_jalr || (dec.is_br && br_cond);
  assign target = dec.is_jalr ? ((rs1_data + imm) & ~XLEN'(1)) : (if_pc_i + imm);

  always_comb begin
    case (dec.op1_sel)
      OP1_ZERO: op1 = '0;
      OP1_PC:   op1 = if_pc_i;
      OP1_PC4:  op1 = if_pc_i + XLEN'(4);
      default:  op1 = rs1_data;
    endcase
  end
  assign op2 = dec.op2_imm ? imm : rs2_data;

  // While squashing, anything not at the latched target is swallowed
  // without looking at hazards or EX back-pressure.
  assign discard = (state_q == ST_SQUASH) && (if_pc_i != target_q);
  assign issue   = if_valid_i && if_ready_o && !discard;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush_i)    state_d = ST_RUN;
    else if (issue) state_d = taken ? ST_SQUASH : ST_RUN;
  end

  // FSM: outputs
  always_comb begin
    if (discard) if_ready_o = 1'b1;
    else         if_ready_o = !hazard && (!ex_valid_q || ex_ready_i);
  end

  // EX pipeline register and one-shot pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_aluop_q    <= '0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_imm_q      <= '0;
      ex_pc_q       <= '0;
      ex_rd_q       <= '0;
      ex_wreg_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
      target_q      <= '0;
    end else begin
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
      if (flush_i) begin
        ex_valid_q <= 1'b0;
      end else if (issue) begin
        ex_valid_q <= 1'b1;
        ex_aluop_q <= dec.aluop;
        ex_op1_q   <= op1;
        ex_op2_q   <= op2;
        ex_imm_q   <= imm;
        ex_pc_q    <= if_pc_i;
        ex_rd_q    <= dec.illegal ? '0 : REG_AW'(if_inst_i[11:7]);
        ex_wreg_q  <= dec.wreg;
        illegal_q  <= dec.illegal;
        redirect_q <= taken;
        if (taken) begin
          redirect_pc_q <= target;
          target_q      <= target;
        end
      end else if (ex_ready_i) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_aluop_o    = ex_aluop_q;
  assign ex_op1_o      = ex_op1_q;
  assign ex_op2_o      = ex_op2_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_pc_o       = ex_pc_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_wreg_o     = ex_wreg_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: hand-encoded instructions, expected
// values written out by hand, one line printed per driven instruction.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, flush_i, if_valid_i, if_ready_o, ex_valid_o, ex_ready_i;
  logic [31:0] if_pc_i, if_inst_i, rf_rdata1_i, rf_rdata2_i;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o, ex_rd_o;
  logic [1:0]  fwd_valid_i, fwd_pend_i;
  logic [9:0]  fwd_rd_i;
  logic [63:0] fwd_data_i;
  logic [5:0]  ex_aluop_o;
  logic [31:0] ex_op1_o, ex_op2_o, ex_imm_o, ex_pc_o, redirect_pc_o;
  logic        ex_wreg_o, redirect_o, illegal_o;

  logic [31:0] rf_mem [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_rdata1_i = rf_mem[rf_raddr1_o];
  assign rf_rdata2_i = rf_mem[rf_raddr2_o];

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .fwd_valid_i(fwd_valid_i), .fwd_pend_i(fwd_pend_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_aluop_o(ex_aluop_o),
    .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
    .ex_rd_o(ex_rd_o), .ex_wreg_o(ex_wreg_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .illegal_o(illegal_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] inst);
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst;
    $display("[TB] drive pc=0x%08h inst=0x%08h flush=%0d ex_ready=%0d", pc, inst, flush_i, ex_ready_i);
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rst = 1'b1; flush_i = 1'b0; if_valid_i = 1'b0; if_pc_i = '0; if_inst_i = '0;
    ex_ready_i = 1'b1; fwd_valid_i = '0; fwd_pend_i = '0; fwd_rd_i = '0; fwd_data_i = '0;
    tick(); tick();

    // Reset values
    chk("rst_ex_valid", ex_valid_o, 0);
    chk("rst_redirect", redirect_o, 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_op1", ex_op1_o, 0);
    chk("rst_pc", ex_pc_o, 0);
    chk("rst_wreg", ex_wreg_o, 0);
    rst = 1'b0;

    // ADDI x1,x0,-5 at 0x100
    rf_mem[1] = 32'h99; rf_mem[2] = 32'd7;
    put(32'h100, enc_i(32'hFFFF_FFFB, 5'd0, 3'd0, 5'd1, 7'h13));
    #1 chk("addi_ready", if_ready_o, 1);
    tick();
    chk("addi_valid", ex_valid_o, 1);
    chk("addi_op1", ex_op1_o, 0);
    chk("addi_imm", ex_imm_o, 32'hFFFF_FFFB);
    chk("addi_op2", ex_op2_o, 32'hFFFF_FFFB);
    chk("addi_rd", ex_rd_o, 1);
    chk("addi_wreg", ex_wreg_o, 1);
    chk("addi_pc", ex_pc_o, 32'h100);

    // ADD x3,x1,x2 with both sources hitting x1: youngest wins
    fwd_valid_i = 2'b11; fwd_rd_i = {5'd1, 5'd1}; fwd_data_i = {32'h22, 32'h11};
    put(32'h104, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    tick();
    chk("add_fwd_op1", ex_op1_o, 32'h11);
    chk("add_fwd_op2", ex_op2_o, 32'd7);
    chk("add_fwd_rd", ex_rd_o, 3);

    // ADD x3,x0,x2 with forwards on x0: still zero
    fwd_rd_i = {5'd0, 5'd0};
    put(32'h108, enc_r(7'h00, 5'd2, 5'd0, 3'd0, 5'd3));
    tick();
    chk("add_x0_op1", ex_op1_o, 0);
    chk("add_x0_op2", ex_op2_o, 32'd7);

    // Load-use: x1 pending on source 0 for 3 cycles
    fwd_valid_i = 2'b01; fwd_pend_i = 2'b01; fwd_rd_i = {5'd0, 5'd1}; fwd_data_i = {32'h0, 32'h55};
    put(32'h10C, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4));
    #1 chk("hz_ready_c1", if_ready_o, 0);
    tick();
    chk("hz_bubble", ex_valid_o, 0);
    chk("hz_ready_c2", if_ready_o, 0);
    tick();
    chk("hz_ready_c3", if_ready_o, 0);
    tick();
    fwd_pend_i = 2'b00;
    #1 chk("hz_ready_clear", if_ready_o, 1);
    tick();
    chk("hz_issue_valid", ex_valid_o, 1);
    chk("hz_issue_op1", ex_op1_o, 32'h55);
    chk("hz_issue_pc", ex_pc_o, 32'h10C);
    if_valid_i = 1'b0;
    tick();
    chk("hz_no_dup", ex_valid_o, 0);
    fwd_valid_i = 2'b00;

    // BLT x1,x2,+16 at 0x200 with x1=-1, x2=1 (signed compare -> taken)
    rf_mem[1] = 32'hFFFF_FFFF; rf_mem[2] = 32'd1;
    put(32'h200, enc_b(32'd16, 5'd2, 5'd1, 3'd4));
    tick();
    chk("blt_redirect", redirect_o, 1);
    chk("blt_target", redirect_pc_o, 32'h210);
    chk("blt_valid", ex_valid_o, 1);
    chk("blt_aluop", ex_aluop_o, 11);
    chk("blt_wreg", ex_wreg_o, 0);
    put(32'h204, enc_i(32'd1, 5'd0, 3'd0, 5'd5, 7'h13));
    #1 chk("sq_ready", if_ready_o, 1);
    tick();
    chk("sq_204_valid", ex_valid_o, 0);
    chk("sq_redirect_once", redirect_o, 0);
    put(32'h208, 32'hFFFF_FFFF);
    tick();
    chk("sq_208_valid", ex_valid_o, 0);
    chk("sq_208_illegal", illegal_o, 0);
    put(32'h210, enc_i(32'd7, 5'd0, 3'd0, 5'd6, 7'h13));
    tick();
    chk("sq_210_valid", ex_valid_o, 1);
    chk("sq_210_pc", ex_pc_o, 32'h210);
    chk("sq_210_rd", ex_rd_o, 6);

    // BLTU with the same operands: 0xFFFFFFFF < 1 unsigned is false
    put(32'h214, enc_b(32'd16, 5'd2, 5'd1, 3'd6));
    tick();
    chk("bltu_redirect", redirect_o, 0);
    chk("bltu_valid", ex_valid_o, 1);
    put(32'h218, enc_i(32'd3, 5'd0, 3'd0, 5'd7, 7'h13));
    tick();
    chk("after_bltu_pc", ex_pc_o, 32'h218);

    // JALR x1,x5,3 with x5=0x1000 at 0x300
    rf_mem[5] = 32'h1000;
    put(32'h300, enc_i(32'd3, 5'd5, 3'd0, 5'd1, 7'h67));
    tick();
    chk("jalr_redirect", redirect_o, 1);
    chk("jalr_target", redirect_pc_o, 32'h1002);
    chk("jalr_link", ex_op1_o, 32'h304);
    chk("jalr_aluop", ex_aluop_o, 33);
    put(32'h1002, enc_i(32'd2, 5'd0, 3'd0, 5'd7, 7'h13));
    tick();
    chk("jalr_tgt_valid", ex_valid_o, 1);
    chk("jalr_tgt_pc", ex_pc_o, 32'h1002);

    // JAL x1,+8 at 0xFFFFFFFC: target and link both wrap
    put(32'hFFFF_FFFC, enc_j(32'd8, 5'd1));
    tick();
    chk("jal_wrap_target", redirect_pc_o, 32'h4);
    chk("jal_wrap_link", ex_op1_o, 32'h0);
    chk("jal_aluop", ex_aluop_o, 32);
    put(32'h4, enc_i(32'd1, 5'd0, 3'd0, 5'd8, 7'h13));
    tick();
    chk("jal_tgt_pc", ex_pc_o, 32'h4);

    // Illegal word issues as a NOP with a one-cycle illegal_o
    put(32'h600, 32'hFFFF_FFFF);
    tick();
    chk("ill_pulse", illegal_o, 1);
    chk("ill_valid", ex_valid_o, 1);
    chk("ill_wreg", ex_wreg_o, 0);
    put(32'h604, enc_i(32'd9, 5'd0, 3'd0, 5'd8, 7'h13));
    tick();
    chk("ill_once", illegal_o, 0);

    // Flush together with a taken BEQ x0,x0,+8
    flush_i = 1'b1;
    put(32'h400, enc_b(32'd8, 5'd0, 5'd0, 3'd0));
    tick();
    chk("flush_redirect", redirect_o, 0);
    chk("flush_valid", ex_valid_o, 0);
    flush_i = 1'b0;
    put(32'h700, enc_i(32'h123, 5'd0, 3'd0, 5'd9, 7'h13));
    tick();
    chk("post_flush_valid", ex_valid_o, 1);
    chk("post_flush_pc", ex_pc_o, 32'h700);

    // Back-pressure for 4 cycles holds the payload
    ex_ready_i = 1'b0;
    put(32'h704, enc_i(32'd5, 5'd0, 3'd0, 5'd10, 7'h13));
    #1 chk("bp_ready", if_ready_o, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("bp_valid", ex_valid_o, 1);
      chk("bp_pc", ex_pc_o, 32'h700);
      chk("bp_imm", ex_imm_o, 32'h123);
      chk("bp_rd", ex_rd_o, 9);
    end
    ex_ready_i = 1'b1;
    #1 chk("bp_release_ready", if_ready_o, 1);
    tick();
    chk("bp_next_pc", ex_pc_o, 32'h704);
    chk("bp_next_imm", ex_imm_o, 32'd5);
    if_valid_i = 1'b0;
    tick();
    chk("bp_drain", ex_valid_o, 0);

    // Async reset while squashing returns to RUN
    put(32'h800, enc_j(32'd8, 5'd0));
    tick();
    chk("rs_redirect", redirect_o, 1);
    if_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rs_async_clear", redirect_o, 0);
    rst = 1'b0;
    put(32'h900, enc_i(32'd4, 5'd0, 3'd0, 5'd11, 7'h13));
    tick();
    chk("rs_run_valid", ex_valid_o, 1);
    chk("rs_run_pc", ex_pc_o, 32'h900);
    if_valid_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Registered, parametrised RV32I decode stage between IF and EX. Decodes one instruction per cycle, reads and forwards operands from a configurable number of bypass sources, and stalls on load-use hazards. Resolves branches/JAL/JALR and issues a one-shot PC redirect, squashing wrong-path fetches until the target arrives. All EX-facing outputs come from a pipeline register with a valid/ready handshake.

## Interface
- XLEN, 32: datapath width.
- FWD_PORTS, 2: bypass sources; index 0 is the youngest and has the highest priority.
- REG_AW, 5: register address width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  external kill (exception): drop pipeline register and squash state.
- if_valid_i / if_ready_o  in/out  1  IF handshake.
- if_pc_i  in  XLEN  PC of if_inst_i.
- if_inst_i  in  32  instruction word.
- rf_raddr1_o, rf_raddr2_o  out  REG_AW  combinational regfile read addresses (rs1, rs2).
- rf_rdata1_i, rf_rdata2_i  in  XLEN  regfile data, same cycle.
- fwd_valid_i  in  FWD_PORTS  source n writes a register.
- fwd_pend_i  in  FWD_PORTS  source n data not yet available (load in flight).
- fwd_rd_i  in  FWD_PORTS*REG_AW  destination of source n.
- fwd_data_i  in  FWD_PORTS*XLEN  data of source n.
- ex_valid_o / ex_ready_i  out/in  1  EX handshake.
- ex_aluop_o  out  6  ALU op code (shared code set).
- ex_op1_o, ex_op2_o, ex_imm_o, ex_pc_o  out  XLEN  operands, immediate, PC.
- ex_rd_o  out  REG_AW  destination register.
- ex_wreg_o  out  1  write-back enable.
- redirect_o  out  1  one-cycle pulse: fetch from redirect_pc_o.
- redirect_pc_o  out  XLEN  target address.
- illegal_o  out  1  one-cycle pulse: undecodable instruction accepted (issued as a NOP).

## Operation
- Immediates are sign-extended per format (I/S/B/U/J). SLTIU immediate is sign-extended as well (RV spec). Shift amount is inst[24:20], zero-extended.
- Operand source: rs==0 → 0; else the lowest n with fwd_valid_i[n] && fwd_rd_i[n]==rs; else rf data. Operands not read take ex_imm_o (op2) or the PC (op1, for AUIPC/JAL/JALR).
- Hazard: a read operand whose selected source has fwd_pend_i set. The instruction is held (if_ready_o=0) until the hazard clears. No bubble is produced while ex_valid_o is held by back-pressure.
- Branch compare uses the forwarded operands, signed for BLT/BGE and unsigned for BLTU/BGEU.
- Targets: branch/JAL = pc+imm; JALR = (rs1+imm)&~1. Link value for JAL/JALR = pc+4, carried on ex_op1_o with aluop Jal/Jalr.
- FSM states:
  - RUN: accept when if_valid_i && if_ready_o. A taken transfer → SQUASH, latch target.
  - SQUASH: if_ready_o=1. Instructions with if_pc_i ≠ target are discarded, with no EX write and no illegal_o. The matching PC is treated as in RUN and returns the FSM to RUN (or to SQUASH again if it is itself taken).
  - flush_i from either state: go to RUN, ex_valid_o←0, no redirect.
- if_ready_o in RUN = !hazard && (!ex_valid_o || ex_ready_i).

## Timing
- Reset: every output 0, state RUN, latched target 0.
- Latency: IF accept in cycle t → ex_valid_o and payload in t+1. The payload is held stable while ex_valid_o && !ex_ready_i.
- redirect_o and redirect_pc_o are registered and asserted exactly in t+1 for one cycle. illegal_o is asserted likewise.
- Simultaneous flush_i and a taken accept: flush wins; no redirect, ex_valid_o←0.
- Redirect target equal to pc (self-loop): the next arrival at that PC matches; no deadlock.
- PC arithmetic wraps modulo 2^XLEN.
- Asynchronous reset mid-SQUASH returns to RUN immediately.

## Structure
- Opcode, funct3/funct7 and aluop constants live in the shared defines package, with a new Jalr/Jal link encoding.
- FSM state encoding is local.
- One sub-module, id_operand_fwd, instantiated twice. It is the parametrised rs → {data, hazard} mux over FWD_PORTS sources plus the regfile.

## Test plan
- ADDI x1,x0,-5 at pc 0x100, ex_ready_i=1 → next cycle ex_op1_o=0, ex_imm_o=0xFFFF_FFFB, ex_rd_o=1, ex_wreg_o=1.
- ADD x3,x1,x2 with fwd[0]=(x1,0x11) and fwd[1]=(x1,0x22), rf x2=7 → ex_op1_o=0x11, ex_op2_o=7. With rs1=x0 and fwd on rd 0 → ex_op1_o=0.
- fwd_pend_i[0]=1 on x1 for 3 cycles → if_ready_o=0 for 3 cycles, one issue afterwards, no duplicate.
- BLT x1,x2,+16 at 0x200 with x1=-1, x2=1 → redirect_o pulse, redirect_pc_o=0x210. Wrong-path 0x204 and 0x208 are discarded; 0x210 is issued.
- JALR x1,x5,3 with x5=0x1000 at 0x300 → redirect_pc_o=0x1002, ex_op1_o=0x304.
- flush_i in the same cycle as a taken BEQ accept → no redirect_o, ex_valid_o=0 the next cycle. ex_ready_i=0 for 4 cycles holds the payload unchanged.
